cgra_bitstream_server: RTL and testbench
========================================

CGRA_BITSTREAM_SERVER -- requirements
Module: cgra_bitstream_server

Interface
REQ-001 Parameter CONFIG_WIDTH, default 64: width of one configuration frame word.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the frame address buses.
REQ-003 Parameter DEPTH, default 1024: number of frame words stored; power of two.
REQ-004 Parameter READ_LATENCY, default 1, legal range 1..4: cycles from accepted mem_read to mem_valid.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 mem_read  in  1  loader read request; one request per cycle when high.
REQ-008 mem_addr  in  ADDR_WIDTH  frame word address, sampled with mem_read.
REQ-009 mem_rdata  out  CONFIG_WIDTH  returned frame word.
REQ-010 mem_valid  out  1  one-cycle qualifier for mem_rdata.
REQ-011 mem_err  out  1  one-cycle flag, coincident with mem_valid, for an out-of-range address.
REQ-012 host_we  in  1  host frame-write request.
REQ-013 host_addr  in  ADDR_WIDTH  host write address.
REQ-014 host_wdata  in  CONFIG_WIDTH  host write data.
REQ-015 host_wready  out  1  host write accepted this cycle when host_we is also high.
REQ-016 wr_protect  in  1  blocks all host writes while high.
REQ-017 stats_clr  in  1  synchronous clear of read_count and checksum.
REQ-018 busy  out  1  high while any read is in flight in the latency pipeline.
REQ-019 read_count  out  16  number of mem_valid pulses served; saturating.
REQ-020 checksum  out  CONFIG_WIDTH  running XOR of every mem_rdata word delivered with mem_valid.

Function
REQ-021 Every mem_read cycle is accepted; there is no back-pressure toward the loader.
REQ-022 An accepted read produces exactly one mem_valid pulse exactly READ_LATENCY cycles later; back-to-back reads produce back-to-back pulses in request order.
REQ-023 Address at or above DEPTH: mem_rdata = 0 and mem_err = 1 with that read's mem_valid; memory is not accessed.
REQ-024 mem_rdata holds its last value while mem_valid is low.
REQ-025 host_wready = !wr_protect, combinationally; a write occurs on a clock edge where host_we and host_wready are both high.
REQ-026 A host write to an out-of-range address is accepted and discarded.
REQ-027 A same-cycle read and write to the same address: the read returns the pre-write data; the next read returns the new data.
REQ-028 busy is high whenever any pipeline stage holds a valid entry, including the delivery cycle.
REQ-029 read_count increments on each mem_valid, including error responses, and saturates at 0xFFFF.
REQ-030 checksum is updated with checksum XOR mem_rdata on each mem_valid; error responses contribute 0.
REQ-031 When stats_clr and mem_valid occur in the same cycle, stats_clr wins: both read_count and checksum become 0.
REQ-032 Arithmetic uses index = mem_addr[log2(DEPTH)-1:0] only after the range check passes; upper address bits are never silently wrapped.

Reset
REQ-033 On rst_n low: mem_valid=0, mem_err=0, mem_rdata=0, busy=0, read_count=0, checksum=0, and all pipeline valid bits are cleared immediately.
REQ-034 Reads in flight at reset are discarded; no mem_valid pulse follows reset release without a new request.
REQ-035 Storage array contents are not reset and survive a reset.

Structure
REQ-036 CONFIG_WIDTH, ADDR_WIDTH and the READ_LATENCY legal range are defined in shared package cgra_pkg.
REQ-037 The latency pipeline (valid, error, data stages) is the sub-module cgra_bitstream_rd_pipe, instantiated once.

Verification
REQ-038 Host writes of 0xAAAA_AAAA_AAAA_0000+i to addresses 0..15, followed by 16 consecutive reads from 0 -> 16 mem_valid pulses with matching data, read_count=16, checksum equal to the XOR of the 16 words.
REQ-039 Run at READ_LATENCY=3 with a read of address 5 -> mem_valid exactly 3 cycles after the request, and busy high for those 3 cycles.
REQ-040 A read of address 1024 with DEPTH=1024 -> mem_valid=1, mem_err=1, mem_rdata=0, read_count+1, checksum unchanged.
REQ-041 Same-cycle host write of 0xBBBB to address 7 (old value 0xAAAA_AAAA_AAAA_0013) and read of address 7 -> old value returned; next read of address 7 -> 0xBBBB.
REQ-042 With wr_protect=1, a host write of 0x1234 to address 2 -> host_wready=0, and a later read of address 2 returns the prior contents.
REQ-043 rst_n asserted with 2 reads in flight -> no mem_valid after reset release, read_count=0, and a read of address 0 returns the data written before reset.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared CGRA configuration constants and helpers for the bitstream server.
// Holds default bus widths and the legal read-latency window.
package cgra_pkg;

   localparam int DEF_CONFIG_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH   = 32;
   localparam int READ_LAT_MIN     = 1;
   localparam int READ_LAT_MAX     = 4;

   function automatic bit read_lat_legal(input int lat);
      return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
   endfunction

endpackage

// File: rtl/cgra_bitstream_rd_pipe.sv
// Read-latency pipeline carrying valid, error and data; LAT cycles input to output.
// No backpressure: one entry accepted per cycle, output data holds between valid pulses.
module cgra_bitstream_rd_pipe
   import cgra_pkg::*;
#(
   parameter int LAT = 1,
   parameter int W   = DEF_CONFIG_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic         in_err,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   output logic         out_err,
   output logic [W-1:0] out_dat,
   output logic         busy
);

   logic [LAT-1:0] vld;
   logic [LAT-1:0] err;
   logic [W-1:0]   dat [LAT];

   // Data stages only load behind a valid entry, so bubbles never disturb the held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         err <= '0;
         for (int i = 0; i < LAT; i++) dat[i] <= '0;
      end else begin
         vld[0] <= in_vld;
         err[0] <= in_vld & in_err;
         if (in_vld) dat[0] <= in_dat;
         for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            err[i] <= err[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign out_vld = vld[LAT-1];
   assign out_err = err[LAT-1];
   assign out_dat = dat[LAT-1];
   assign busy    = |vld;

endmodule

// File: rtl/cgra_bitstream_server.sv
// Configuration frame store: host writes frames, loader reads them back after READ_LATENCY cycles.
// No backpressure toward the loader; host writes are refused only while wr_protect is high.
module cgra_bitstream_server
   import cgra_pkg::*;
#(
   parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mem_read,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [CONFIG_WIDTH-1:0] mem_rdata,
   output logic                    mem_valid,
   output logic                    mem_err,
   input  logic                    host_we,
   input  logic [ADDR_WIDTH-1:0]   host_addr,
   input  logic [CONFIG_WIDTH-1:0] host_wdata,
   output logic                    host_wready,
   input  logic                    wr_protect,
   input  logic                    stats_clr,
   output logic                    busy,
   output logic [15:0]             read_count,
   output logic [CONFIG_WIDTH-1:0] checksum
);

   localparam int IDX_W = $clog2(DEPTH);

   if (!read_lat_legal(READ_LATENCY)) begin : g_bad_latency
      $error("cgra_bitstream_server: READ_LATENCY out of range");
   end

   logic [CONFIG_WIDTH-1:0] mem [DEPTH];

   logic                    rd_in_range;
   logic                    wr_in_range;
   logic [IDX_W-1:0]        rd_idx;
   logic [IDX_W-1:0]        wr_idx;
   logic [CONFIG_WIDTH-1:0] rd_word;

   // Full-width compare so addresses beyond DEPTH never alias onto a low index.
   assign rd_in_range = (mem_addr  < ADDR_WIDTH'(DEPTH));
   assign wr_in_range = (host_addr < ADDR_WIDTH'(DEPTH));
   assign rd_idx      = mem_addr[IDX_W-1:0];
   assign wr_idx      = host_addr[IDX_W-1:0];
   assign rd_word     = rd_in_range ? mem[rd_idx] : '0;

   assign host_wready = !wr_protect;

   // Storage is intentionally unreset; frames survive a reset of the control path.
   always_ff @(posedge clk) begin
      if (host_we && host_wready && wr_in_range) mem[wr_idx] <= host_wdata;
   end

   cgra_bitstream_rd_pipe #(
      .LAT (READ_LATENCY),
      .W   (CONFIG_WIDTH)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (mem_read),
      .in_err  (!rd_in_range),
      .in_dat  (rd_word),
      .out_vld (mem_valid),
      .out_err (mem_err),
      .out_dat (mem_rdata),
      .busy    (busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_count <= '0;
         checksum   <= '0;
      end else if (stats_clr) begin
         read_count <= '0;
         checksum   <= '0;
      end else if (mem_valid) begin
         if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
         checksum <= checksum ^ mem_rdata;
      end
   end

endmodule

// File: tb/tb_cgra_bitstream_server.sv
// Directed self-checking bench for cgra_bitstream_server at READ_LATENCY=3, DEPTH=1024.
module tb_cgra_bitstream_server;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic        mem_valid;
   logic        mem_err;
   logic        host_we;
   logic [31:0] host_addr;
   logic [63:0] host_wdata;
   logic        host_wready;
   logic        wr_protect;
   logic        stats_clr;
   logic        busy;
   logic [15:0] read_count;
   logic [63:0] checksum;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_count;
   logic [63:0] exp_cs;

   always #5 clk = ~clk;

   cgra_bitstream_server #(
      .CONFIG_WIDTH (64),
      .ADDR_WIDTH   (32),
      .DEPTH        (1024),
      .READ_LATENCY (LAT)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_read    (mem_read),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .mem_err     (mem_err),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_wready (host_wready),
      .wr_protect  (wr_protect),
      .stats_clr   (stats_clr),
      .busy        (busy),
      .read_count  (read_count),
      .checksum    (checksum)
   );

   task automatic host_write(input logic [31:0] a, input logic [63:0] d);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      @(posedge clk); #1;
      host_we = 1'b0;
   endtask

   // Issues one read in the current cycle and returns the first response and its latency (-1 on timeout).
   task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic e, output int lat);
      mem_read = 1'b1; mem_addr = a; lat = -1; d = '0; e = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_valid && lat < 0) begin lat = k; d = mem_rdata; e = mem_err; end
         @(posedge clk); #1;
         mem_read = 1'b0;
         if (lat >= 0) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_valid); end
      checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mem_err); end
      checks++; if (mem_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (read_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", read_count); end
      checks++; if (checksum !== 64'h0) begin errors++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
      checks++; if (host_wready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b expected 1", host_wready); end
      rst_n = 1'b1;
      exp_count = '0; exp_cs = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_stream();
      logic [63:0] words [16];
      int          n = 0;
      for (int i = 0; i < 16; i++) begin
         words[i] = 64'hAAAA_AAAA_AAAA_0000 + 64'(i);
         host_write(32'(i), words[i]);
      end
      for (int c = 0; c < 16 + LAT + 3; c++) begin
         mem_read = (c < 16); mem_addr = 32'(c);
         @(negedge clk);
         if (mem_valid) begin
            if (n < 16) begin
               checks++;
               if (mem_rdata !== words[n] || mem_err !== 1'b0) begin
                  errors++; $display("FAIL stream_data[%0d]: got %h err=%b expected %h err=0", n, mem_rdata, mem_err, words[n]);
               end
               exp_cs ^= words[n];
            end
            n++;
         end
         @(posedge clk); #1;
      end
      mem_read = 1'b0;
      exp_count += 16'(n);
      checks++; if (n != 16) begin errors++; $display("FAIL stream_pulses: got %0d expected 16", n); end
      checks++; if (read_count !== 16'd16) begin errors++; $display("FAIL stream_count: got %0d expected 16", read_count); end
      checks++; if (checksum !== exp_cs) begin errors++; $display("FAIL stream_checksum: got %h expected %h", checksum, exp_cs); end
   endtask

   task automatic test_latency();
      logic exp_v, exp_b;
      mem_read = 1'b1; mem_addr = 32'd5;
      for (int k = 0; k <= LAT + 2; k++) begin
         @(negedge clk);
         exp_v = (k == LAT);
         exp_b = (k >= 1 && k <= LAT);
         checks++; if (mem_valid !== exp_v) begin errors++; $display("FAIL lat_valid[%0d]: got %b expected %b", k, mem_valid, exp_v); end
         checks++; if (busy !== exp_b) begin errors++; $display("FAIL lat_busy[%0d]: got %b expected %b", k, busy, exp_b); end
         if (k >= LAT) begin
            checks++;
            if (mem_rdata !== 64'hAAAA_AAAA_AAAA_0005) begin
               errors++; $display("FAIL lat_rdata_hold[%0d]: got %h expected aaaaaaaaaaaa0005", k, mem_rdata);
            end
         end
         @(posedge clk); #1;
         mem_read = 1'b0;
      end
      exp_count += 1; exp_cs ^= 64'hAAAA_AAAA_AAAA_0005;
      checks++; if (read_count !== exp_count) begin errors++; $display("FAIL lat_count: got %0d expected %0d", read_count, exp_count); end
   endtask

   task automatic test_oob();
      logic [63:0] d; logic e; int lat;
      host_write(32'd1027, 64'hDEAD_BEEF_DEAD_BEEF);
      do_read(32'd1024, d, e, lat);
      exp_count += 1;
      checks++; if (lat != LAT) begin errors++; $display("FAIL oob_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (e !== 1'b1 || d !== 64'h0) begin errors++; $display("FAIL oob_resp: got err=%b data=%h expected err=1 data=0", e, d); end
      checks++; if (read_count !== exp_count) begin errors++; $display("FAIL oob_count: got %0d expected %0d", read_count, exp_count); end
      checks++; if (checksum !== exp_cs) begin errors++; $display("FAIL oob_checksum: got %h expected %h", checksum, exp_cs); end
      do_read(32'd3, d, e, lat);
      exp_count += 1; exp_cs ^= 64'hAAAA_AAAA_AAAA_0003;
      checks++; if (d !== 64'hAAAA_AAAA_AAAA_0003 || e !== 1'b0) begin errors++; $display("FAIL oob_no_alias: got %h err=%b expected aaaaaaaaaaaa0003 err=0", d, e); end
   endtask

   task automatic test_same_cycle();
      logic [63:0] got [2];
      int n = 0;
      host_write(32'd7, 64'hAAAA_AAAA_AAAA_0013);
      host_we = 1'b1; host_addr = 32'd7; host_wdata = 64'hBBBB;
      mem_read = 1'b1; mem_addr = 32'd7;
      @(posedge clk); #1;
      host_we = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_valid) begin
            if (n < 2) got[n] = mem_rdata;
            n++;
         end
         @(posedge clk); #1;
         mem_read = 1'b0;
      end
      checks++; if (n != 2) begin errors++; $display("FAIL rw_pulses: got %0d expected 2", n); end
      checks++; if (got[0] !== 64'hAAAA_AAAA_AAAA_0013) begin errors++; $display("FAIL rw_old: got %h expected aaaaaaaaaaaa0013", got[0]); end
      checks++; if (got[1] !== 64'hBBBB) begin errors++; $display("FAIL rw_new: got %h expected bbbb", got[1]); end
      exp_count += 2; exp_cs ^= 64'hAAAA_AAAA_AAAA_0013 ^ 64'hBBBB;
      checks++; if (checksum !== exp_cs) begin errors++; $display("FAIL rw_checksum: got %h expected %h", checksum, exp_cs); end
   endtask

   task automatic test_protect();
      logic [63:0] d; logic e; int lat;
      wr_protect = 1'b1;
      host_we = 1'b1; host_addr = 32'd2; host_wdata = 64'h1234;
      @(negedge clk);
      checks++; if (host_wready !== 1'b0) begin errors++; $display("FAIL protect_wready: got %b expected 0", host_wready); end
      @(posedge clk); #1;
      host_we = 1'b0; wr_protect = 1'b0;
      do_read(32'd2, d, e, lat);
      exp_count += 1; exp_cs ^= 64'hAAAA_AAAA_AAAA_0002;
      checks++; if (d !== 64'hAAAA_AAAA_AAAA_0002) begin errors++; $display("FAIL protect_data: got %h expected aaaaaaaaaaaa0002", d); end
   endtask

   task automatic test_stats_clr();
      logic [63:0] d; logic e; int lat;
      mem_read = 1'b1; mem_addr = 32'd1;
      @(posedge clk); #1;
      mem_read = 1'b0;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      stats_clr = 1'b1;
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL clr_coincident_valid: got %b expected 1", mem_valid); end
      @(posedge clk); #1;
      stats_clr = 1'b0;
      exp_count = '0; exp_cs = '0;
      checks++; if (read_count !== 16'h0 || checksum !== 64'h0) begin errors++; $display("FAIL clr_wins: got count=%0d cs=%h expected 0 and 0", read_count, checksum); end
      do_read(32'd4, d, e, lat);
      exp_count += 1; exp_cs ^= 64'hAAAA_AAAA_AAAA_0004;
      checks++; if (read_count !== exp_count || checksum !== exp_cs) begin errors++; $display("FAIL clr_after: got count=%0d cs=%h expected %0d %h", read_count, checksum, exp_count, exp_cs); end
   endtask

   task automatic test_reset_inflight();
      logic [63:0] d; logic e; int lat;
      int pulses = 0;
      mem_read = 1'b1; mem_addr = 32'd0;
      @(posedge clk); #1;
      mem_addr = 32'd1;
      @(posedge clk); #1;
      mem_read = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got valid=%b busy=%b expected 0 0", mem_valid, busy); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_count = '0; exp_cs = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_valid) pulses++;
      end
      @(posedge clk); #1;
      checks++; if (pulses != 0) begin errors++; $display("FAIL rst_no_pulse: got %0d expected 0", pulses); end
      checks++; if (read_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %0d expected 0", read_count); end
      do_read(32'd0, d, e, lat);
      checks++; if (d !== 64'hAAAA_AAAA_AAAA_0000 || lat != LAT) begin errors++; $display("FAIL rst_mem_kept: got %h lat=%0d expected aaaaaaaaaaaa0000 lat=%0d", d, lat, LAT); end
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_addr = '0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0;
      wr_protect = 1'b0; stats_clr = 1'b0;
      exp_count = '0; exp_cs = '0;
      test_reset();
      test_fill_stream();
      test_latency();
      test_oob();
      test_same_cycle();
      test_protect();
      test_stats_clr();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
